byte_serializer_tx: RTL and testbench

//  Downstream stage of the phy_tx byte mux. Accepts the interleaved 8-bit stream (data + valid) into a small FIFO.

---
 rtl/byte_serializer_tx.sv | 137 +++++++++++++
 tb/tb_byte_serializer_tx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_serializer_tx.sv
// Byte FIFO feeding an MSB-first serializer that fills empty slots with IDLE_BYTE.
// Define SERIALIZER_PARITY_EN to append an odd-parity bit after every frame's LSB.
module byte_serializer_tx #(
  parameter int                DATA_W     = 8,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] IDLE_BYTE  = DATA_W'(8'hBC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              serial_out,
  output logic              byte_start,
  output logic              sending_data,
  output logic              overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
`ifdef SERIALIZER_PARITY_EN
  localparam int FRAME_LEN = DATA_W + 1;
`else
  localparam int FRAME_LEN = DATA_W;
`endif
  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              overflow_q, overflow_d;

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              serial_q, serial_d;
  logic              start_q, start_d;
  logic              sending_q, sending_d;
`ifdef SERIALIZER_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic              push, pop, load;
  logic [DATA_W-1:0] frame_byte;

  // ready comes from the registered count, so a full FIFO rejects even when popping
  assign ready_out  = (count_q != FULL_CNT);
  assign push       = valid_in && ready_out;
  assign load       = (bit_cnt_q == LAST_BIT);
  assign pop        = load && (count_q != '0);
  assign frame_byte = pop ? mem_q[rd_ptr_q] : IDLE_BYTE;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (valid_in & ~ready_out);
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    serial_d  = serial_q;
    start_d   = 1'b0;
    sending_d = sending_q;
`ifdef SERIALIZER_PARITY_EN
    parity_d  = parity_q;
`endif
    if (load) begin
      serial_d  = frame_byte[DATA_W-1];
      shift_d   = {frame_byte[DATA_W-2:0], 1'b0};
      bit_cnt_d = '0;
      start_d   = 1'b1;
      sending_d = pop;
`ifdef SERIALIZER_PARITY_EN
      parity_d  = ~^frame_byte;
`endif
    end else begin
      serial_d  = shift_q[DATA_W-1];
      shift_d   = {shift_q[DATA_W-2:0], 1'b0};
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
`ifdef SERIALIZER_PARITY_EN
      // The slot after the LSB carries the odd-parity bit
      if (bit_cnt_q == CNT_W'(DATA_W - 1)) serial_d = parity_q;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      shift_q    <= '0;
      bit_cnt_q  <= LAST_BIT;
      serial_q   <= 1'b0;
      start_q    <= 1'b0;
      sending_q  <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      serial_q   <= serial_d;
      start_q    <= start_d;
      sending_q  <= sending_d;
`ifdef SERIALIZER_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  // Storage needs no reset; only entries behind a valid count are ever read
  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wr_ptr_q] <= data_in;
  end

  assign serial_out   = serial_q;
  assign byte_start   = start_q;
  assign sending_data = sending_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_byte_serializer_tx.sv
// Bench for byte_serializer_tx: a negedge monitor rebuilds frames and checks them against a scoreboard.
module tb_byte_serializer_tx;

`ifdef SERIALIZER_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif
  localparam logic [7:0] IDLE = 8'hBC;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       ready_out, serial_out, byte_start, sending_data, overflow;

  int testsRun = 0;
  int testsFailed = 0;

  logic [7:0] sbQueue[$];
  logic [8:0] frameLog[$];

  typedef struct {
    logic [7:0] data;
    logic       valid;
    logic       expReady;
    logic       expOverflow;
  } vec_t;
  vec_t vecs[10];

  always #5 clk = ~clk;

  byte_serializer_tx dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .serial_out   (serial_out),
    .byte_start   (byte_start),
    .sending_data (sending_data),
    .overflow     (overflow)
  );

  function automatic void checkOutput(input string name, input logic [31:0] actual,
                                      input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endfunction

  // Frame reassembly: every completed frame is compared with the scoreboard or IDLE
  int             bitIdx = 0;
  logic           collecting = 1'b0;
  logic           frameSend = 1'b0;
  logic [FRAME-1:0] frameBits = '0;
  logic [7:0]     monByte;

  always @(negedge clk) begin
    if (reset) begin
      collecting = 1'b0;
      bitIdx = 0;
    end else begin
      if (byte_start) begin
        if (collecting) checkOutput("byte_start period", bitIdx, FRAME);
        collecting = 1'b1;
        bitIdx = 0;
        frameSend = sending_data;
        frameBits = '0;
      end else if (collecting && bitIdx == FRAME) begin
        checkOutput("byte_start after frame", byte_start, 1'b1);
        collecting = 1'b0;
      end
      if (collecting && bitIdx < FRAME) begin
        frameBits = {frameBits[FRAME-2:0], serial_out};
        if (sending_data !== frameSend) checkOutput("sending_data stable", sending_data, frameSend);
        bitIdx++;
        if (bitIdx == FRAME) begin
          monByte = frameBits[FRAME-1 -: 8];
`ifdef SERIALIZER_PARITY_EN
          checkOutput("odd parity", ^frameBits, 1'b1);
`endif
          if (frameSend) begin
            checkOutput("data frame has queued byte", sbQueue.size() != 0, 1'b1);
            if (sbQueue.size() != 0) checkOutput("data byte", monByte, sbQueue.pop_front());
          end else begin
            checkOutput("idle byte", monByte, IDLE);
          end
          frameLog.push_back({frameSend, monByte});
        end
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] d, input logic v, input logic expReady);
    checkOutput("ready_out", ready_out, expReady);
    if (v && expReady) sbQueue.push_back(d);
    data_in = d;
    valid_in = v;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    valid_in = 1'b0;
    sbQueue.delete();
    frameLog.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic waitStart(input logic wantData, input int maxCycles, input string name);
    int n = 0;
    logic found = 1'b0;
    while (!found && n < maxCycles) begin
      @(negedge clk);
      n++;
      if (byte_start && sending_data == wantData) found = 1'b1;
    end
    checkOutput(name, found, 1'b1);
  endtask

  task automatic waitDrain(input int maxCycles);
    int n = 0;
    while (sbQueue.size() != 0 && n < maxCycles) begin
      @(posedge clk);
      n++;
    end
    checkOutput("scoreboard drained", sbQueue.size(), 0);
  endtask

  task automatic checkLog(input int idx, input logic [8:0] expected);
    if (frameLog.size() > idx) checkOutput($sformatf("frame %0d", idx), frameLog[idx], expected);
    else checkOutput("frame log length", frameLog.size(), idx + 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{8'h01, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h02, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h03, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h04, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'h05, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{8'h06, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{8'h00, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{8'h00, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{8'h00, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{8'h00, 1'b0, 1'b1, 1'b1};

    // Reset state, then a free-running IDLE line
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset serial_out", serial_out, 1'b0);
    checkOutput("reset byte_start", byte_start, 1'b0);
    checkOutput("reset sending_data", sending_data, 1'b0);
    checkOutput("reset overflow", overflow, 1'b0);
    checkOutput("reset ready_out", ready_out, 1'b1);
    reset = 1'b0;
    idleCycles(32);
    checkOutput("idle frames seen", frameLog.size() >= 3, 1'b1);
    foreach (frameLog[i]) checkOutput("idle log entry", frameLog[i], {1'b0, IDLE});
    checkOutput("idle overflow", overflow, 1'b0);

    // Single byte pushed in the middle of an IDLE frame
    waitStart(1'b0, 20, "idle frame start");
    frameLog.delete();
    idleCycles(2);
    applyStimulus(8'hA5, 1'b1, 1'b1);
    waitDrain(40);
    idleCycles(10);
    checkLog(0, {1'b0, IDLE});
    checkLog(1, {1'b1, 8'hA5});
    checkLog(2, {1'b0, IDLE});

    // Overflow: six pushes from the first edge after reset release
    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].data, vecs[i].valid, vecs[i].expReady);
      checkOutput($sformatf("overflow row %0d", i), overflow, vecs[i].expOverflow);
    end
    idleCycles(45);
    checkLog(0, {1'b0, IDLE});
    checkLog(1, {1'b1, 8'h01});
    checkLog(2, {1'b1, 8'h02});
    checkLog(3, {1'b1, 8'h03});
    checkLog(4, {1'b1, 8'h04});
    checkLog(5, {1'b0, IDLE});
    checkOutput("scoreboard empty after overflow", sbQueue.size(), 0);

    // Reset while A5 is mid-frame and two more bytes are queued
    applyStimulus(8'hA5, 1'b1, 1'b1);
    applyStimulus(8'h11, 1'b1, 1'b1);
    applyStimulus(8'h22, 1'b1, 1'b1);
    waitStart(1'b1, 40, "A5 frame start");
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    sbQueue.delete();
    frameLog.delete();
    @(posedge clk);
    #1;
    checkOutput("mid reset serial_out", serial_out, 1'b0);
    checkOutput("mid reset overflow", overflow, 1'b0);
    checkOutput("mid reset ready_out", ready_out, 1'b1);
    checkOutput("mid reset sending_data", sending_data, 1'b0);
    reset = 1'b0;
    idleCycles(10);
    checkLog(0, {1'b0, IDLE});

    // Push and pop on the same load edge with two bytes already queued
    doReset();
    waitStart(1'b0, 20, "load edge sync");
    applyStimulus(8'h3C, 1'b1, 1'b1);
    applyStimulus(8'hC3, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(8'h00, 1'b0, 1'b1);
    applyStimulus(8'h5A, 1'b1, 1'b1);
    applyStimulus(8'h0F, 1'b1, 1'b1);
    applyStimulus(8'hF0, 1'b1, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b0);
    waitDrain(80);
    checkOutput("push/pop overflow", overflow, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
